// File: rtl/ext_bus_bridge.sv
// Bridge for CPU data accesses outside the internal memory window: drives a four-phase
// req/ack handshake on the external bus, stalls the CPU meanwhile and aborts on timeout.
module ext_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] Address,
  input  logic [31:0] DataIn,
  input  logic        RE,
  input  logic        WE,
  input  logic        Saida,
  input  logic        ErrClr,
  output logic [31:0] DataOut,
  output logic        Stall,
  output logic        BusError,
  output logic [15:0] ExtAddr,
  output logic [31:0] ExtWData,
  output logic        ExtWE,
  output logic        ExtReq,
  input  logic        ExtAck,
  input  logic [31:0] ExtRData
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StReq     = 3'd1;
  localparam logic [2:0] StRelease = 3'd2;
  localparam logic [2:0] StAbort   = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     data_out_q, data_out_d;
  logic [15:0]     ext_addr_q, ext_addr_d;
  logic [31:0]     ext_wdata_q, ext_wdata_d;
  logic            ext_we_q, ext_we_d;
  logic            ext_req_q, ext_req_d;
  logic            bus_error_q, bus_error_d;
  logic            acc;

  assign acc = (RE | WE) & Saida;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = ext_we_q;
    ext_req_d   = ext_req_q;
    bus_error_d = bus_error_q;
    if (ErrClr) begin
      bus_error_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (acc) begin
          ext_addr_d  = Address;
          ext_wdata_d = DataIn;
          ext_we_d    = WE;
          ext_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (ExtAck) begin
          if (!ext_we_q) begin
            data_out_d = ExtRData;
          end
          ext_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = StRelease;
        end else if (cnt_q == CntLast) begin
          ext_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = StAbort;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (!ExtAck) begin
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StAbort;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAbort: begin
        // Set overrides a concurrent ErrClr.
        bus_error_d = 1'b1;
        if (!ext_we_q) begin
          data_out_d = 32'hFFFF_FFFF;
        end
        cnt_d   = '0;
        state_d = StDone;
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        ext_req_d = 1'b0;
        cnt_d     = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_out_q  <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      ext_req_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      ext_req_q   <= ext_req_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Gated by reset so the CPU is released immediately when a transfer is abandoned.
  assign Stall = RST & (((state_q == StIdle) & acc) | (state_q == StReq) |
                        (state_q == StRelease) | (state_q == StAbort));

  assign DataOut  = data_out_q;
  assign BusError = bus_error_q;
  assign ExtAddr  = ext_addr_q;
  assign ExtWData = ext_wdata_q;
  assign ExtWE    = ext_we_q;
  assign ExtReq   = ext_req_q;

endmodule
